// File: rtl/ama_riscv_fetch.sv
// Instruction-fetch stage: owns the IF program counter, drives the synchronous
// IMEM and presents the ID-stage instruction/PC with squash, stall-hold and boot bubble.
module ama_riscv_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 14,
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         pc_sel,
  input  logic               pc_we,
  input  logic               stall_if,
  input  logic               clear_if,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        bp_target,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_if,
  output logic [31:0]        pc_id,
  output logic [31:0]        inst_id,
  output logic               fetch_valid_id,
  output logic [31:0]        inst_cnt
);

  typedef enum logic [1:0] {
    PC_SEL_INC = 2'd0,
    PC_SEL_ALU = 2'd1,
    PC_SEL_BP  = 2'd2,
    PC_SEL_RST = 2'd3
  } pc_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e      state, state_nxt;
  logic [31:0] pc_target;
  logic [31:0] next_pc;
  logic        kill_q;
  logic [31:0] hold_q, hold_q_nxt;
  logic        hold_v, hold_v_nxt;
  logic [31:0] run_inst;
  logic        run_valid;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    pc_target = pc_if + 32'd4;
    case (pc_sel_e'(pc_sel))
      PC_SEL_INC: pc_target = pc_if + 32'd4;
      PC_SEL_ALU: pc_target = alu_out;
      PC_SEL_BP:  pc_target = bp_target;
      PC_SEL_RST: pc_target = RESET_VEC;
      default:    pc_target = pc_if + 32'd4;
    endcase
    next_pc = {pc_target[31:2], 2'b00};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always_ff blocks evaluate in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_if <= RESET_VEC;
      pc_id <= RESET_VEC;
    end else if (!stall_if) begin
      if (pc_we) pc_if <= next_pc;
      pc_id <= pc_if;
    end
  end

  assign imem_en   = !rst;
  assign imem_addr = pc_if[IMEM_AW+1:2];

  // The IMEM word arriving next cycle belongs to a squashed PC; resets to 1 for the boot bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            kill_q <= 1'b1;
    else if (clear_if)  kill_q <= 1'b1;
    else if (!stall_if) kill_q <= 1'b0;
  end

  assign run_inst  = kill_q ? NOP : imem_rdata;
  assign run_valid = !kill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      hold_q <= NOP;
      hold_v <= 1'b0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_q_nxt;
      hold_v <= hold_v_nxt;
    end
  end

  // During a stall IMEM re-reads the held IF PC, so ID must replay a captured copy.
  always_comb begin
    state_nxt      = state;
    hold_q_nxt     = hold_q;
    hold_v_nxt     = hold_v;
    inst_id        = run_inst;
    fetch_valid_id = run_valid;
    case (state)
      ST_RUN: begin
        if (stall_if) begin
          state_nxt = ST_HOLD;
          if (clear_if) begin
            hold_q_nxt = NOP;
            hold_v_nxt = 1'b0;
          end else begin
            hold_q_nxt = run_inst;
            hold_v_nxt = run_valid;
          end
        end
      end
      ST_HOLD: begin
        inst_id        = hold_q;
        fetch_valid_id = hold_v;
        if (stall_if) begin
          if (clear_if) begin
            hold_q_nxt = NOP;
            hold_v_nxt = 1'b0;
          end
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              inst_cnt <= 32'd0;
    else if (fetch_valid_id && !stall_if) inst_cnt <= inst_cnt + 32'd1;
  end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Bench for ama_riscv_fetch: directed stimulus pushes expected ID retirements into a
// scoreboard queue; a negedge monitor pops and compares whenever an instruction leaves ID.
module tb_ama_riscv_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic        stall_if;
  logic        clear_if;
  logic [31:0] alu_out;
  logic [31:0] bp_target;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if;
  logic [31:0] pc_id;
  logic [31:0] inst_id;
  logic        fetch_valid_id;
  logic [31:0] inst_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  logic [31:0] mem [0:16383];

  ama_riscv_fetch #(
    .RESET_VEC(32'h0000_0000),
    .IMEM_AW  (14),
    .NOP      (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_sel        (pc_sel),
    .pc_we         (pc_we),
    .stall_if      (stall_if),
    .clear_if      (clear_if),
    .alu_out       (alu_out),
    .bp_target     (bp_target),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_if         (pc_if),
    .pc_id         (pc_id),
    .inst_id       (inst_id),
    .fetch_valid_id(fetch_valid_id),
    .inst_cnt      (inst_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous IMEM: word i holds 32'h5A00_0000 | i.
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 | i;
    imem_rdata = 32'h0;
  end

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    sb_q.push_back(e);
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic cyc(input logic we, input logic [1:0] sel, input logic st, input logic clr,
                     input logic [31:0] alu, input logic [31:0] bp);
    @(posedge clk);
    #1;
    pc_we     = we;
    pc_sel    = sel;
    stall_if  = st;
    clear_if  = clr;
    alu_out   = alu;
    bp_target = bp;
    @(negedge clk);
  endtask

  task automatic run();
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_if"}, pc_if, 32'h0);
    check({tag, "_pc_id"}, pc_id, 32'h0);
    check({tag, "_inst_id"}, inst_id, NOP);
    check({tag, "_valid"}, {31'd0, fetch_valid_id}, 32'd0);
    check({tag, "_imem_en"}, {31'd0, imem_en}, 32'd0);
    check({tag, "_inst_cnt"}, inst_cnt, 32'd0);
  endtask

  // Scoreboard monitor: an instruction leaves ID when valid and not stalled.
  always @(negedge clk) begin
    if (!rst && fetch_valid_id && !stall_if) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire: got pc=%h inst=%h expected none", pc_id, inst_id);
      end else begin
        mon_e = sb_q.pop_front();
        check("retire_pc", pc_id, mon_e.pc);
        check("retire_inst", inst_id, mon_e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pc_we     = 1'b1;
    pc_sel    = 2'd0;
    stall_if  = 1'b0;
    clear_if  = 1'b0;
    alu_out   = 32'h0;
    bp_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_imem_addr", {18'd0, imem_addr}, 32'd0);

    // Boot: bubble first, then A, B, C from RESET_VEC.
    @(posedge clk);
    #1 rst = 1'b0;
    push(32'h0000_0000, 32'h5A00_0000);
    push(32'h0000_0004, 32'h5A00_0001);
    push(32'h0000_0008, 32'h5A00_0002);
    @(negedge clk);
    check("boot_bubble_inst", inst_id, NOP);
    check("boot_bubble_valid", {31'd0, fetch_valid_id}, 32'd0);
    run();
    run();

    // Redirect through alu_out with squash, while C is in ID.
    push(32'h0000_0100, 32'h5A00_0040);
    cyc(1'b1, 2'd1, 1'b0, 1'b1, 32'h0000_0102, 32'h0);
    run();
    check("redirect_pc_if", pc_if, 32'h0000_0100);
    check("redirect_nop_inst", inst_id, NOP);
    check("redirect_nop_valid", {31'd0, fetch_valid_id}, 32'd0);
    check("boot_inst_cnt", inst_cnt, 32'd3);
    push(32'h0000_0104, 32'h5A00_0041);
    run();

    // Stall three cycles while 0x104 sits in ID.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0);
      check("stall_inst", inst_id, 32'h5A00_0041);
      check("stall_pc_id", pc_id, 32'h0000_0104);
      check("stall_pc_if", pc_if, 32'h0000_0108);
      check("stall_inst_cnt", inst_cnt, 32'd4);
    end
    push(32'h0000_0108, 32'h5A00_0042);
    run();
    check("release_inst", inst_id, 32'h5A00_0041);
    run();

    // Squash during stall, then release with a redirect to 0x200.
    cyc(1'b1, 2'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    cyc(1'b1, 2'd0, 1'b1, 1'b1, 32'h0, 32'h0);
    check("sq_stall_inst", inst_id, NOP);
    check("sq_stall_valid", {31'd0, fetch_valid_id}, 32'd0);
    push(32'h0000_0200, 32'h5A00_0080);
    cyc(1'b1, 2'd1, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
    check("sq_release_inst", inst_id, NOP);
    check("sq_release_valid", {31'd0, fetch_valid_id}, 32'd0);
    run();
    check("sq_redirect_pc_if", pc_if, 32'h0000_0200);
    check("sq_redirect_nop", inst_id, NOP);

    // Predictor target at the top of the address space, then PC+4 wraps.
    push(32'hFFFF_FFFC, 32'h5A00_3FFF);
    cyc(1'b1, 2'd2, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFE);
    run();
    check("bp_pc_if", pc_if, 32'hFFFF_FFFC);
    check("bp_nop", inst_id, NOP);
    push(32'h0000_0000, 32'h5A00_0000);
    run();
    check("wrap_pc_if", pc_if, 32'h0000_0000);
    cyc(1'b1, 2'd3, 1'b0, 1'b1, 32'h0, 32'h0);
    check("pre_rstvec_pc_if", pc_if, 32'h0000_0004);
    run();
    check("rstvec_pc_if", pc_if, 32'h0000_0000);
    check("rstvec_nop", inst_id, NOP);

    // Enter HOLD, then assert reset asynchronously mid-cycle.
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("hold_inst", inst_id, 32'h5A00_0000);
    check("hold_inst_cnt", inst_cnt, 32'd9);
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("hold2_inst", inst_id, 32'h5A00_0000);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midstall_reset");
    sb_q.delete();
    push(32'h0000_0000, 32'h5A00_0000);
    push(32'h0000_0004, 32'h5A00_0001);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    stall_if = 1'b0;
    clear_if = 1'b0;
    pc_we    = 1'b1;
    pc_sel   = 2'd0;
    @(negedge clk);
    check("reboot_bubble_inst", inst_id, NOP);
    check("reboot_bubble_valid", {31'd0, fetch_valid_id}, 32'd0);
    run();
    run();
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
